imm_extend_pipe: RTL and testbench
==================================

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 The block SHALL have parameter IN_W, default 16, immediate input width in bits.
REQ-002 The block SHALL have parameter OUT_W, default 32, extended output width in bits; legal only when OUT_W >= IN_W+2.
REQ-003 The block SHALL have parameter DEPTH, default 2, output buffer entries; legal range 1..16.
REQ-004 The block SHALL use one clock and a synchronous, active-low reset: clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-006 in_valid  input  1  producer presents an immediate.
REQ-007 in_ready  output  1  block accepts the immediate this cycle.
REQ-008 in_imm  input  IN_W  raw immediate field.
REQ-009 in_mode  input  2  extension mode: 00 zero, 01 sign, 10 upper, 11 branch.
REQ-010 out_valid  output  1  out_data/out_mode hold a valid result.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 out_data  output  OUT_W  extended immediate.
REQ-013 out_mode  output  2  mode that produced out_data.
REQ-014 xfer_cnt  output  16  count of completed output transfers.

Function
REQ-015 Input transfer SHALL occur on a rising clk where in_valid=1 and in_ready=1; output transfer where out_valid=1 and out_ready=1.
REQ-016 Mode 00 SHALL produce in_imm zero-extended to OUT_W.
REQ-017 Mode 01 SHALL produce in_imm sign-extended to OUT_W (replicate bit IN_W-1).
REQ-018 Mode 10 SHALL place in_imm in bits [OUT_W-1:OUT_W-IN_W], all lower bits zero.
REQ-019 Mode 11 SHALL sign-extend in_imm to OUT_W, shift left by 2, and discard the two bits shifted out of the MSB end.
REQ-020 Results SHALL be computed at input transfer and written, with their mode, into a FIFO of DEPTH entries; out_data/out_mode SHALL show the FIFO head.
REQ-021 Latency SHALL be one cycle: an input transferred at edge N makes out_valid=1 after edge N when the FIFO was empty; no combinational path from in_* to out_*.
REQ-022 in_ready SHALL equal (occupancy < DEPTH) AND rst_n=1; it SHALL NOT depend on out_ready.
REQ-023 out_valid SHALL equal (occupancy > 0).
REQ-024 Simultaneous input and output transfer SHALL leave occupancy unchanged and preserve FIFO order.
REQ-025 Read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-026 out_data/out_mode SHALL stay stable while out_valid=1 and out_ready=0.
REQ-027 When occupancy=0, out_data and out_mode SHALL read 0.
REQ-028 xfer_cnt SHALL increment by 1 on each output transfer and wrap from 0xFFFF to 0x0000.
REQ-029 in_imm/in_mode SHALL be ignored on cycles without an input transfer.

Reset
REQ-030 While rst_n=0 at a rising clk: occupancy, pointers and xfer_cnt SHALL become 0; out_valid=0, out_data=0, out_mode=0.
REQ-031 in_ready SHALL be 0 while rst_n=0 and 1 on the first cycle after rst_n returns to 1.
REQ-032 Reset mid-operation SHALL discard all buffered entries; no transfer completes on a reset edge.

Verification
REQ-033 Defaults; in_imm=0x8001, mode 01 then 00 with out_ready=1 -> out_data 0xFFFF8001 then 0x00008001, each one cycle after acceptance; xfer_cnt=2.
REQ-034 in_imm=0x1234 mode 10 -> 0x12340000; in_imm=0xFFFF mode 11 -> 0xFFFFFFFC; in_imm=0x7FFF mode 11 -> 0x0001FFFC.
REQ-035 out_ready=0, push 3 items -> in_ready=0 after 2 accepted; out_data holds first result stable; release out_ready -> both results in order, in_ready returns to 1.
REQ-036 DEPTH=2, continuous in_valid and out_ready=1 for 10 items -> one transfer per cycle, order preserved across pointer wrap, xfer_cnt=10.
REQ-037 Fill FIFO with 2 entries, assert rst_n=0 for one edge -> out_valid=0, out_data=0, xfer_cnt=0, in_ready=1 next cycle.
REQ-038 Preload xfer_cnt to 0xFFFF via transfers, one more transfer -> xfer_cnt=0x0000.

Source files
------------

// File: rtl/imm_extend_pipe.sv
// Immediate extender with a DEPTH-entry result FIFO. Results are computed on input
// transfer, so there is no combinational path from in_* to out_*.
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       out_mode,
  output logic [15:0]      xfer_cnt
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

  typedef struct packed {
    logic [1:0]       mode;
    logic [OUT_W-1:0] data;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          wr_ent;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            push, pop;
  logic [OUT_W-1:0] sext;

  assign in_ready  = (count < DEPTH_C) && rst_n;
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    sext        = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};
    wr_ent      = '0;
    wr_ent.mode = in_mode;
    unique case (in_mode)
      2'b00:   wr_ent.data = {{(OUT_W-IN_W){1'b0}}, in_imm};
      2'b01:   wr_ent.data = sext;
      2'b10:   wr_ent.data = {in_imm, {(OUT_W-IN_W){1'b0}}};
      default: wr_ent.data = {sext[OUT_W-3:0], 2'b00};
    endcase
  end

  // Storage needs no reset: the head is masked to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_ent;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      xfer_cnt <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_P) ? '0 : wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr   <= (rd_ptr == LAST_P) ? '0 : rd_ptr + PW'(1);
        xfer_cnt <= xfer_cnt + 16'd1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign out_data = out_valid ? mem[rd_ptr].data : '0;
  assign out_mode = out_valid ? mem[rd_ptr].mode : 2'b00;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe at default parameters (16 -> 32, DEPTH 2).
module tb_imm_extend_pipe;
  logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_imm, xfer_cnt;
  logic [1:0]  in_mode, out_mode;
  logic [31:0] out_data;
  int tests = 0, fails = 0;

  imm_extend_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_imm(in_imm), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode),
    .xfer_cnt(xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] m);
    logic [31:0] s;
    s = imm[15] ? (32'hFFFF0000 | 32'(imm)) : 32'(imm);
    case (m)
      2'd0:    return 32'(imm);
      2'd1:    return s;
      2'd2:    return 32'(imm) << 16;
      default: return s << 2;
    endcase
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 0; in_valid = 0; out_ready = 0; in_imm = '0; in_mode = '0;
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst_n = 0; in_valid = 1; in_imm = 16'hABCD; in_mode = 2'd1; out_ready = 1;
    @(negedge clk);
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    @(posedge clk); @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++; if (out_data !== 32'h0 || out_mode !== 2'd0) begin fails++; $display("FAIL reset_out_data got %h/%0d want 0/0", out_data, out_mode); end
    tests++; if (xfer_cnt !== 16'h0) begin fails++; $display("FAIL reset_xfer_cnt got %h want 0", xfer_cnt); end
    #1 rst_n = 1; in_valid = 0;
    @(negedge clk);
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_release_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_modes();
    logic [15:0] imms [5] = '{16'h8001, 16'h8001, 16'h1234, 16'hFFFF, 16'h7FFF};
    logic [1:0]  mds  [5] = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd3};
    logic [31:0] exps [5] = '{32'hFFFF8001, 32'h00008001, 32'h12340000, 32'hFFFFFFFC, 32'h0001FFFC};
    do_reset();
    out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_imm = imms[i]; in_mode = mds[i];
      @(posedge clk); #1;
      in_valid = 0; in_imm = 16'h5A5A; in_mode = 2'd2;
      @(negedge clk);
      tests++; if (out_valid !== 1'b1 || out_data !== exps[i] || out_mode !== mds[i]) begin
        fails++; $display("FAIL mode_%0d got v=%b %h/%0d want v=1 %h/%0d", i, out_valid, out_data, out_mode, exps[i], mds[i]);
      end
      @(posedge clk); #1;
      @(negedge clk);
      tests++; if (out_valid !== 1'b0 || xfer_cnt !== 16'(i + 1)) begin
        fails++; $display("FAIL mode_drain_%0d got v=%b cnt=%0d want v=0 cnt=%0d", i, out_valid, xfer_cnt, i + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 0;
    in_valid = 1; in_imm = 16'h0001; in_mode = 2'd0;
    @(posedge clk); #1;
    in_imm = 16'h8000; in_mode = 2'd1;
    @(posedge clk); #1;
    in_imm = 16'h00FF; in_mode = 2'd2;
    @(negedge clk);
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_full_in_ready got %b want 0", in_ready); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if (out_data !== 32'h00000001 || out_mode !== 2'd0 || out_valid !== 1'b1) begin
      fails++; $display("FAIL bp_head_stable got v=%b %h/%0d want v=1 00000001/0", out_valid, out_data, out_mode);
    end
    #1 in_valid = 0; out_ready = 1;
    @(posedge clk); @(negedge clk);
    tests++; if (out_data !== 32'hFFFF8000 || out_mode !== 2'd1 || in_ready !== 1'b1) begin
      fails++; $display("FAIL bp_second got %h/%0d rdy=%b want ffff8000/1 rdy=1", out_data, out_mode, in_ready);
    end
    @(posedge clk); @(negedge clk);
    tests++; if (out_valid !== 1'b0 || out_data !== 32'h0 || xfer_cnt !== 16'd2) begin
      fails++; $display("FAIL bp_drained got v=%b %h cnt=%0d want v=0 0 cnt=2", out_valid, out_data, xfer_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] imm;
    logic [31:0] exp;
    do_reset();
    out_ready = 1;
    in_valid = 1; in_imm = 16'hFF00; in_mode = 2'd0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i < 9) begin in_imm = 16'hFF00 + 16'(i + 1); in_mode = 2'(i + 1); end
      else in_valid = 0;
      @(negedge clk);
      imm = 16'hFF00 + 16'(i);
      exp = ref_ext(imm, 2'(i));
      tests++; if (out_valid !== 1'b1 || out_data !== exp || out_mode !== 2'(i) || in_ready !== 1'b1) begin
        fails++; $display("FAIL b2b_%0d got v=%b %h/%0d rdy=%b want v=1 %h/%0d rdy=1", i, out_valid, out_data, out_mode, in_ready, exp, i % 4);
      end
    end
    @(posedge clk); @(negedge clk);
    tests++; if (out_valid !== 1'b0 || xfer_cnt !== 16'd10) begin
      fails++; $display("FAIL b2b_count got v=%b cnt=%0d want v=0 cnt=10", out_valid, xfer_cnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1; in_valid = 1; in_imm = 16'h0042; in_mode = 2'd0;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #1;
    out_ready = 0; in_valid = 1; in_imm = 16'h0011;
    repeat (2) @(posedge clk);
    #1 in_valid = 0;
    @(negedge clk);
    tests++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || xfer_cnt !== 16'd1) begin
      fails++; $display("FAIL mid_prefill got v=%b rdy=%b cnt=%0d want v=1 rdy=0 cnt=1", out_valid, in_ready, xfer_cnt);
    end
    #1 rst_n = 0; in_valid = 1; out_ready = 1;
    @(posedge clk); #1;
    rst_n = 1; in_valid = 0; out_ready = 0;
    @(negedge clk);
    tests++; if (out_valid !== 1'b0 || out_data !== 32'h0 || xfer_cnt !== 16'h0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL mid_reset got v=%b %h cnt=%0d rdy=%b want v=0 0 cnt=0 rdy=1", out_valid, out_data, xfer_cnt, in_ready);
    end
  endtask

  task automatic test_cnt_wrap();
    do_reset();
    out_ready = 1; in_valid = 1; in_imm = 16'h0003; in_mode = 2'd3;
    repeat (65535) @(posedge clk);
    #1 in_valid = 0;
    @(posedge clk); @(negedge clk);
    tests++; if (xfer_cnt !== 16'hFFFF || out_valid !== 1'b0) begin
      fails++; $display("FAIL wrap_preload got cnt=%h v=%b want cnt=ffff v=0", xfer_cnt, out_valid);
    end
    #1 in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    tests++; if (out_data !== 32'h0000000C) begin fails++; $display("FAIL wrap_data got %h want 0000000c", out_data); end
    @(posedge clk); @(negedge clk);
    tests++; if (xfer_cnt !== 16'h0000) begin fails++; $display("FAIL wrap_cnt got %h want 0000", xfer_cnt); end
  endtask

  initial begin
    rst_n = 0; in_valid = 0; out_ready = 0; in_imm = '0; in_mode = '0;
    test_reset();
    test_modes();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_cnt_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
